// File: rtl/ifetch_pq.sv
// Prefetch-queue instruction fetch: streams sequential words from a 1-cycle RAM into a
// DEPTH-entry FIFO, with redirect, prioritised interrupt/fault vectoring and a loader hold.
module ifetch_pq #(
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 4,
    parameter int                NUM_IRQ   = 9,
    parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] VEC_BASE  = 32'h0000_0100,
    parameter logic [ADDR_W-1:0] FAULT_VEC = 32'h0000_0100
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [31:0]                  mem_rdata,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [31:0]                  inst_data,
    output logic [ADDR_W-1:0]            inst_pc,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    input  logic [NUM_IRQ-1:0]           pending_interrupts,
    input  logic                         irq_en,
    input  logic                         is_usage_fault,
    output logic                         irq_ack,
    output logic [$clog2(NUM_IRQ+1)-1:0] irq_id,
    output logic [ADDR_W-1:0]            return_addr,
    input  logic                         program_off
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int IW = $clog2(NUM_IRQ + 1);
    localparam logic [CW:0] OCC_MAX = (CW + 1)'(DEPTH);

    logic [31:0]       fifo_data [DEPTH];
    logic [CW-1:0]     count;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic              inflight;
    logic              off_q;
    logic [ADDR_W-1:0] fetch_pc, deliver_pc;

    logic              take_fault, take_redir, take_irq, restart, event_take, flush;
    logic [IW-1:0]     irq_num;
    logic [ADDR_W-1:0] target;
    logic              has_head, deq, deq_fifo, enq;
    logic [CW:0]       occ;
    logic [31:0]       head_data;

    // Lowest set line wins; loop runs high-to-low so the last hit is the lowest index.
    always_comb begin
        irq_num = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (pending_interrupts[i]) irq_num = IW'(i + 1);
    end

    always_comb begin
        take_fault = is_usage_fault;
        take_redir = !is_usage_fault && redirect_valid;
        take_irq   = !is_usage_fault && !redirect_valid && irq_en
                     && (pending_interrupts != '0) && !program_off;
        restart    = off_q && !program_off;
        event_take = take_fault || take_redir || take_irq || restart;
        flush      = event_take || program_off;
        target     = RESET_PC;
        if (take_fault)      target = FAULT_VEC;
        else if (take_redir) target = redirect_pc;
        else if (take_irq)   target = VEC_BASE + (ADDR_W'(irq_num) << 3);
    end

    // With an empty FIFO the returning RAM word is presented directly (fall-through),
    // so the in-flight slot counts as one unit of queue occupancy.
    assign has_head   = (count != '0) || inflight;
    assign inst_valid = has_head && !flush;
    assign head_data  = (count != '0) ? fifo_data[rd_ptr] : mem_rdata;
    assign inst_data  = inst_valid ? head_data : '0;
    assign inst_pc    = deliver_pc;

    assign deq      = inst_valid && inst_ready;
    assign deq_fifo = deq && (count != '0);
    assign enq      = inflight && !flush && !(deq && (count == '0));
    assign occ      = {1'b0, count} + {{CW{1'b0}}, inflight};

    assign mem_req  = rst && !program_off && !event_take
                      && ((occ < OCC_MAX) || ((occ == OCC_MAX) && deq));
    assign mem_addr = fetch_pc;

    // Stage p1: response capture into the queue
    always_ff @(posedge clk) begin
        if (enq) fifo_data[wr_ptr] <= mem_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            inflight    <= 1'b0;
            off_q       <= 1'b0;
            fetch_pc    <= RESET_PC;
            deliver_pc  <= RESET_PC;
            irq_ack     <= 1'b0;
            irq_id      <= '0;
            return_addr <= '0;
        end else begin
            inflight <= mem_req;
            off_q    <= program_off;
            if (event_take) begin
                fetch_pc   <= target;
                deliver_pc <= target;
            end else begin
                if (mem_req) fetch_pc   <= fetch_pc + ADDR_W'(4);
                if (deq)     deliver_pc <= deliver_pc + ADDR_W'(4);
            end
            if (flush) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count + CW'(enq) - CW'(deq_fifo);
                if (deq_fifo) rd_ptr <= rd_ptr + PW'(1);
                if (enq)      wr_ptr <= wr_ptr + PW'(1);
            end
            irq_ack <= take_fault || take_irq;
            if (take_fault || take_irq) begin
                irq_id      <= take_fault ? '0 : irq_num;
                return_addr <= deliver_pc;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) assert (!(enq && !deq_fifo && (count == CW'(DEPTH))));
    end
endmodule

// File: tb/tb_ifetch_pq.sv
// Directed bench for ifetch_pq: RAM model returns word address (addr>>2); delivered
// instructions are popped from an expected-PC scoreboard queue and compared.
module tb_ifetch_pq;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [8:0]  pending_interrupts;
    logic        irq_en;
    logic        is_usage_fault;
    logic        irq_ack;
    logic [3:0]  irq_id;
    logic [31:0] return_addr;
    logic        program_off;

    int n_pass = 0, n_total = 0, n_fail = 0;
    int nreq = 0, nack = 0, ndeliv = 0;
    logic [31:0] exp_q[$];

    ifetch_pq dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pending_interrupts(pending_interrupts), .irq_en(irq_en),
        .is_usage_fault(is_usage_fault), .irq_ack(irq_ack), .irq_id(irq_id),
        .return_addr(return_addr), .program_off(program_off)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem_req ? (mem_addr >> 2) : $urandom;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic chk_reset_outputs(input string ph);
        chk({ph, "_mem_req"}, mem_req, 0);
        chk({ph, "_mem_addr"}, mem_addr, 0);
        chk({ph, "_inst_valid"}, inst_valid, 0);
        chk({ph, "_inst_data"}, inst_data, 0);
        chk({ph, "_inst_pc"}, inst_pc, 0);
        chk({ph, "_irq_ack"}, irq_ack, 0);
        chk({ph, "_irq_id"}, irq_id, 0);
        chk({ph, "_return_addr"}, return_addr, 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (mem_req) nreq++;
            if (irq_ack) nack++;
            if (inst_valid && inst_ready) begin
                logic [31:0] e;
                ndeliv++;
                n_total++;
                assert (exp_q.size() != 0) n_pass++;
                else begin
                    n_fail++;
                    $error("FAIL deliver_unexpected: observed pc 0x%0h expected no delivery", inst_pc);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("deliver_pc", inst_pc, e);
                    chk("deliver_data", inst_data, e >> 2);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, a0;
        logic [31:0] ret_exp;
        rst = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        pending_interrupts = '0; irq_en = 1'b0; is_usage_fault = 1'b0; program_off = 1'b0;
        repeat (3) step();
        chk_reset_outputs("rst0");

        // Sequential stream at one instruction per cycle
        inst_ready = 1'b1;
        push_stream(32'h0);
        rst = 1'b1;
        #1;
        chk("first_req", mem_req, 1);
        chk("first_addr", mem_addr, 0);
        step();
        chk("first_valid", inst_valid, 1);
        chk("first_pc", inst_pc, 0);
        chk("first_data", inst_data, 0);
        d0 = ndeliv;
        repeat (8) step();
        chk("throughput", 32'(ndeliv - d0), 8);

        // Redirect into backpressure: FIFO fills to DEPTH then requests stop
        redirect_valid = 1'b1; redirect_pc = 32'h200; inst_ready = 1'b0;
        push_stream(32'h200);
        #1;
        chk("evt_no_req", mem_req, 0);
        chk("evt_no_valid", inst_valid, 0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("redir_req", mem_req, 1);
        chk("redir_addr", mem_addr, 32'h200);
        r0 = nreq; d0 = ndeliv;
        repeat (10) step();
        chk("full_reqs", 32'(nreq - r0), 4);
        chk("full_mem_req", mem_req, 0);
        chk("full_valid", inst_valid, 1);
        chk("full_no_pop", 32'(ndeliv - d0), 0);
        inst_ready = 1'b1;
        d0 = ndeliv;
        repeat (6) step();
        chk("drain_count", 32'(ndeliv - d0), 6);

        // Redirect with 3 queued and 1 in flight
        redirect_valid = 1'b1; redirect_pc = 32'h300; inst_ready = 1'b0;
        push_stream(32'h300);
        step();
        redirect_valid = 1'b0;
        repeat (4) step();
        redirect_valid = 1'b1; redirect_pc = 32'h40; inst_ready = 1'b1;
        push_stream(32'h40);
        #1;
        chk("flush_valid", inst_valid, 0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("r40_req", mem_req, 1);
        chk("r40_addr", mem_addr, 32'h40);
        chk("r40_gap", inst_valid, 0);
        step();
        chk("r40_valid", inst_valid, 1);
        chk("r40_pc", inst_pc, 32'h40);
        repeat (3) step();

        // Interrupt with deliver_pc held at 0x1C
        redirect_valid = 1'b1; redirect_pc = 32'h1C; inst_ready = 1'b0;
        push_stream(32'h1C);
        step();
        redirect_valid = 1'b0;
        repeat (2) step();
        pending_interrupts = 9'b0_0001_0100; irq_en = 1'b1;
        push_stream(32'h118);
        #1;
        chk("irq_ack_reg", irq_ack, 0);
        step();
        pending_interrupts = '0; inst_ready = 1'b1;
        #1;
        chk("irq_ack", irq_ack, 1);
        chk("irq_id", irq_id, 3);
        chk("irq_ret", return_addr, 32'h1C);
        chk("irq_addr", mem_addr, 32'h118);
        step();
        chk("irq_ack_once", irq_ack, 0);
        chk("irq_valid", inst_valid, 1);
        chk("irq_pc", inst_pc, 32'h118);
        a0 = nack;
        pending_interrupts = 9'h001; irq_en = 1'b0;
        repeat (4) step();
        chk("irq_disabled", 32'(nack - a0), 0);
        pending_interrupts = '0;

        // Fault + redirect + IRQ together: fault wins, IRQ taken later
        ret_exp = exp_q[0];
        is_usage_fault = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        pending_interrupts = 9'h100; irq_en = 1'b1;
        push_stream(32'h100);
        step();
        is_usage_fault = 1'b0; redirect_valid = 1'b0; irq_en = 1'b0;
        #1;
        chk("flt_ack", irq_ack, 1);
        chk("flt_id", irq_id, 0);
        chk("flt_ret", return_addr, ret_exp);
        chk("flt_req", mem_req, 1);
        chk("flt_addr", mem_addr, 32'h100);
        step();
        chk("flt_valid", inst_valid, 1);
        chk("flt_pc", inst_pc, 32'h100);
        chk("flt_data", inst_data, 32'h40);
        chk("flt_ack_once", irq_ack, 0);
        step();
        ret_exp = exp_q[0];
        irq_en = 1'b1;
        push_stream(32'h148);
        step();
        irq_en = 1'b0; pending_interrupts = '0;
        #1;
        chk("late_irq_ack", irq_ack, 1);
        chk("late_irq_id", irq_id, 9);
        chk("late_irq_ret", return_addr, ret_exp);
        chk("late_irq_addr", mem_addr, 32'h148);
        step();
        chk("late_irq_pc", inst_pc, 32'h148);

        // Loader hold, then restart at RESET_PC
        repeat (2) step();
        program_off = 1'b1;
        push_stream(32'h0);
        r0 = nreq;
        #1;
        chk("off_valid", inst_valid, 0);
        chk("off_req", mem_req, 0);
        repeat (3) step();
        program_off = 1'b0;
        chk("off_no_reqs", 32'(nreq - r0), 0);
        for (int i = 0; i < 6; i++) begin
            step();
            if (inst_valid) break;
        end
        chk("restart_valid", inst_valid, 1);
        chk("restart_pc", inst_pc, 0);
        chk("restart_data", inst_data, 0);

        // Asynchronous reset mid-fetch
        repeat (3) step();
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("rst1");
        repeat (2) step();
        push_stream(32'h0);
        rst = 1'b1;
        #1;
        chk("rst1_req", mem_req, 1);
        chk("rst1_addr", mem_addr, 0);
        step();
        chk("rst1_valid", inst_valid, 1);
        chk("rst1_pc", inst_pc, 0);
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
